op_request_scheduler: RTL and testbench

- Sits between the three request sources (DPP ready, ND ready, NA) and the datapath execution unit.
- Serialises their requests into one opcode stream, issued one at a time with a valid/ack handshake.
- Requests arriving together are captured in sticky pending bits and served round-robin, never collapsed to an undefined opcode.
- Tracks each operation to completion, with a watchdog timeout.

---
 rtl/op_request_scheduler.sv | 152 +++++++++++++++
 tb/tb_op_request_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/op_request_scheduler.sv
// op_request_scheduler
// Serialises DPP-ready, ND-ready and NA requests into a single opcode stream
// toward the datapath. Requests are latched into sticky pending bits, granted
// round-robin (TXE -> RXA -> LOG), issued with a valid/ack handshake and then
// tracked until op_done_in, with a watchdog that aborts a hung operation.
module op_request_scheduler #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dpp_req_in,
    input  logic       nd_req_in,
    input  logic       na_req_in,
    input  logic       op_ack_in,
    input  logic       op_done_in,
    output logic [1:0] opcode_out,
    output logic       op_valid_out,
    output logic       busy_out,
    output logic [2:0] pending_out,
    output logic       overrun_out,
    output logic       timeout_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0]       OP_NOP  = 2'b00;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Source index used by the arbiter: 0 = TXE (dpp), 1 = RXA (nd), 2 = LOG (na).
    // Pending bit for source s lives at r_pend[2-s]; its opcode is s+1.
    state_t           r_state;
    logic [1:0]       r_opcode;
    logic             r_valid;
    logic [2:0]       r_pend;
    logic             r_overrun;
    logic             r_timeout;
    logic [1:0]       r_rr;
    logic [CNT_W-1:0] r_wdog;

    logic [2:0]       w_req;
    logic [2:0]       w_clr;
    logic [1:0]       w_win;
    logic             w_found;
    logic [1:0]       w_rr_next;

    assign w_req     = {dpp_req_in, nd_req_in, na_req_in};
    assign w_rr_next = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;

    // Round-robin search over registered pending bits, starting at r_rr.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr;
        w_clr   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (int'(r_rr) + k) % 3;
            if (!w_found && r_pend[2-s]) begin
                w_found = 1'b1;
                w_win   = 2'(s);
            end
        end
        // A grant only happens (and only clears a bit) while idle.
        if (r_state == ST_IDLE && w_found) begin
            w_clr[2-int'(w_win)] = 1'b1;
        end
    end

    // Sticky pending bits: a new request wins over a same-cycle grant clear;
    // a request hitting an already-set, not-being-cleared bit is an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend    <= 3'b000;
            r_overrun <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_req;
            if (|(w_req & r_pend & ~w_clr)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Issue/execute FSM with registered opcode, valid, rr pointer and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_opcode  <= OP_NOP;
            r_valid   <= 1'b0;
            r_rr      <= 2'd0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_opcode <= OP_NOP;
                    r_valid  <= 1'b0;
                    if (w_found) begin
                        r_opcode <= w_win + 2'd1;
                        r_valid  <= 1'b1;
                        r_rr     <= w_rr_next;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Watchdog is held here; it only measures execution time.
                    if (op_ack_in) begin
                        r_valid <= 1'b0;
                        r_wdog  <= '0;
                        if (op_done_in) begin
                            r_opcode <= OP_NOP;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_valid <= 1'b0;
                    if (op_done_in) begin
                        r_opcode <= OP_NOP;
                        r_state  <= ST_IDLE;
                    end else if (r_wdog == WD_LAST) begin
                        // Abort; the request is dropped, not re-queued.
                        r_timeout <= 1'b1;
                        r_opcode  <= OP_NOP;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_opcode <= OP_NOP;
                    r_valid  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign opcode_out      = r_opcode;
    assign op_valid_out    = r_valid;
    assign busy_out        = (r_state != ST_IDLE);
    assign pending_out     = r_pend;
    assign overrun_out     = r_overrun;
    assign timeout_err_out = r_timeout;

endmodule

// File: tb/tb_op_request_scheduler.sv
// Bench for op_request_scheduler: directed stimulus with a scoreboard of
// expected grant opcodes checked by an independent monitor, plus direct
// checks of status outputs at chosen cycles.
module tb_op_request_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       dpp_req_in, nd_req_in, na_req_in;
    logic       op_ack_in, op_done_in;
    logic [1:0] opcode_out;
    logic       op_valid_out, busy_out, overrun_out, timeout_err_out;
    logic [2:0] pending_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic       prev_v = 1'b0;

    op_request_scheduler #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .dpp_req_in(dpp_req_in), .nd_req_in(nd_req_in), .na_req_in(na_req_in),
        .op_ack_in(op_ack_in), .op_done_in(op_done_in),
        .opcode_out(opcode_out), .op_valid_out(op_valid_out), .busy_out(busy_out),
        .pending_out(pending_out), .overrun_out(overrun_out),
        .timeout_err_out(timeout_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dpp_req_in = 0; nd_req_in = 0; na_req_in = 0;
        op_ack_in = 0; op_done_in = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Ack and done together while ISSUE: operation completes at once.
    task automatic serve();
        op_ack_in = 1; op_done_in = 1;
        tick();
        op_ack_in = 0; op_done_in = 0;
    endtask

    // Monitor: each new issued operation pops the next expected opcode.
    always @(negedge clk) begin
        if (op_valid_out && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_opcode: unexpected grant %0h, none expected at %0t", opcode_out, $time);
            end else begin
                chk("grant_opcode", {6'd0, opcode_out}, {6'd0, exp_q.pop_front()});
            end
        end
        prev_v = op_valid_out;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound 1 expected 0");
        $fatal(1, "bench time limit");
    end

    initial begin
        do_reset();
        chk("rst_opcode",  {6'd0, opcode_out}, 8'd0);
        chk("rst_valid",   {7'd0, op_valid_out}, 8'd0);
        chk("rst_busy",    {7'd0, busy_out}, 8'd0);
        chk("rst_pending", {5'd0, pending_out}, 8'd0);
        chk("rst_overrun", {7'd0, overrun_out}, 8'd0);
        chk("rst_timeout", {7'd0, timeout_err_out}, 8'd0);

        // Single request with ack/done handshake
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        chk("single_pend", {5'd0, pending_out}, 8'b100);
        chk("single_valid_early", {7'd0, op_valid_out}, 8'd0);
        exp_q.push_back(2'b01);
        tick();
        chk("single_valid", {7'd0, op_valid_out}, 8'd1);
        chk("single_busy", {7'd0, busy_out}, 8'd1);
        chk("single_pend_clr", {5'd0, pending_out}, 8'b000);
        op_done_in = 1; tick(); op_done_in = 0;    // spurious done in ISSUE
        chk("issue_hold_valid", {7'd0, op_valid_out}, 8'd1);
        chk("issue_hold_op", {6'd0, opcode_out}, 8'd1);
        op_ack_in = 1; tick(); op_ack_in = 0;
        chk("exec_valid", {7'd0, op_valid_out}, 8'd0);
        chk("exec_op", {6'd0, opcode_out}, 8'd1);
        chk("exec_busy", {7'd0, busy_out}, 8'd1);
        tick(); tick();
        op_done_in = 1; tick(); op_done_in = 0;
        chk("done_op", {6'd0, opcode_out}, 8'd0);
        chk("done_busy", {7'd0, busy_out}, 8'd0);

        // Simultaneous requests after reset: TXE, RXA, LOG
        do_reset();
        dpp_req_in = 1; nd_req_in = 1; na_req_in = 1; tick();
        dpp_req_in = 0; nd_req_in = 0; na_req_in = 0;
        chk("sim_pend0", {5'd0, pending_out}, 8'b111);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        tick(); chk("sim_pend1", {5'd0, pending_out}, 8'b011); serve();
        tick(); chk("sim_pend2", {5'd0, pending_out}, 8'b001); serve();
        tick(); chk("sim_pend3", {5'd0, pending_out}, 8'b000); serve();

        // Round-robin: after TXE grant, LOG beats TXE
        do_reset();
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        exp_q.push_back(2'b01);
        tick(); serve();
        dpp_req_in = 1; na_req_in = 1; tick(); dpp_req_in = 0; na_req_in = 0;
        chk("rr_pend", {5'd0, pending_out}, 8'b101);
        exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        tick(); chk("rr_first_log", {6'd0, opcode_out}, 8'd3); serve();
        tick(); chk("rr_then_txe", {6'd0, opcode_out}, 8'd1); serve();

        // Overrun: nd twice while pending and DUT busy
        do_reset();
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        exp_q.push_back(2'b01);
        tick();
        nd_req_in = 1; tick(); nd_req_in = 0;
        chk("ovr_first", {7'd0, overrun_out}, 8'd0);
        nd_req_in = 1; tick(); nd_req_in = 0;
        chk("ovr_second", {7'd0, overrun_out}, 8'd1);
        serve();
        exp_q.push_back(2'b10);
        tick(); serve(); tick(); tick();
        chk("ovr_sticky", {7'd0, overrun_out}, 8'd1);

        // Set beats clear: nd req on its own grant cycle
        do_reset();
        nd_req_in = 1; tick();
        exp_q.push_back(2'b10); exp_q.push_back(2'b10);
        tick(); nd_req_in = 0;
        chk("sbc_valid", {7'd0, op_valid_out}, 8'd1);
        chk("sbc_pend", {5'd0, pending_out}, 8'b010);
        chk("sbc_no_ovr", {7'd0, overrun_out}, 8'd0);
        serve();
        tick(); chk("sbc_regrant_pend", {5'd0, pending_out}, 8'b000); serve();
        chk("sbc_no_ovr_end", {7'd0, overrun_out}, 8'd0);

        // Timeout with TIMEOUT_CYCLES=8; extra ISSUE wait must not count
        do_reset();
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        exp_q.push_back(2'b01);
        tick(); tick(); tick(); tick();
        op_ack_in = 1; tick(); op_ack_in = 0;          // EXEC cycle 1
        for (int i = 0; i < 7; i++) tick();             // EXEC cycle 8
        chk("to_busy_c8", {7'd0, busy_out}, 8'd1);
        chk("to_err_c8", {7'd0, timeout_err_out}, 8'd0);
        tick();
        chk("to_err_pulse", {7'd0, timeout_err_out}, 8'd1);
        chk("to_idle", {7'd0, busy_out}, 8'd0);
        chk("to_op_nop", {6'd0, opcode_out}, 8'd0);
        tick();
        chk("to_err_one_cycle", {7'd0, timeout_err_out}, 8'd0);

        // Done coinciding with timeout: no error
        do_reset();
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        exp_q.push_back(2'b01);
        tick();
        op_ack_in = 1; tick(); op_ack_in = 0;
        for (int i = 0; i < 7; i++) tick();
        op_done_in = 1; tick(); op_done_in = 0;
        chk("tod_no_err", {7'd0, timeout_err_out}, 8'd0);
        chk("tod_idle", {7'd0, busy_out}, 8'd0);

        // Reset mid-EXEC with two bits pending
        do_reset();
        dpp_req_in = 1; tick(); dpp_req_in = 0;
        exp_q.push_back(2'b01);
        tick();
        op_ack_in = 1; tick(); op_ack_in = 0;
        nd_req_in = 1; na_req_in = 1; tick(); nd_req_in = 0; na_req_in = 0;
        chk("mid_pend", {5'd0, pending_out}, 8'b011);
        reset = 1; tick(); reset = 0;
        chk("mid_rst_pend", {5'd0, pending_out}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy_out}, 8'd0);
        chk("mid_rst_op", {6'd0, opcode_out}, 8'd0);
        chk("mid_rst_valid", {7'd0, op_valid_out}, 8'd0);
        dpp_req_in = 1; nd_req_in = 1; tick(); dpp_req_in = 0; nd_req_in = 0;
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        tick(); chk("mid_next_txe", {6'd0, opcode_out}, 8'd1); serve();
        tick(); serve();
        tick(); tick();

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
